regfile_wb_arbiter: RTL

Shares the single register-file write port (we/waddr/wdata, written on posedge clk) between NREQ writeback requesters, e.g. ALU, load unit and multi-cycle mul/div. Uses a round-robin valid/ready handshake and a registered output stage that drives the register file directly. Writes to $0 are accepted and discarded. An optional bypass forwards the in-flight write to the two read ports.

---
 rtl/regfile_wb_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter that owns the single register-file write port.
// Build option WB_BYPASS_EN forwards the in-flight registered write to both read ports.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int PTRW = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [5*NREQ-1:0]      req_addr,
  input  logic [32*NREQ-1:0]     req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [31:0]            rf_wdata,
  output logic [PTRW-1:0]        grant_id,
  output logic [15:0]            drop_cnt,
  input  logic [4:0]             byp_raddr1,
  input  logic [4:0]             byp_raddr2,
  input  logic [31:0]            byp_rdata1_in,
  input  logic [31:0]            byp_rdata2_in,
  output logic [31:0]            byp_rdata1,
  output logic [31:0]            byp_rdata2
);

  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [31:0]     rf_wdata_q, rf_wdata_d;
  logic [PTRW-1:0] grant_id_q, grant_id_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [PTRW-1:0] rr_ptr_q, rr_ptr_d;

  logic [NREQ-1:0] grant_c;
  logic [PTRW-1:0] gidx_c;
  logic            accept_c;
  logic [PTRW:0]   pos_c;
  logic [4:0]      sel_addr_c;
  logic [31:0]     sel_data_c;

  // Visit positions rr_ptr, rr_ptr+1, ... (mod NREQ); first valid requester wins.
  always_comb begin
    grant_c  = '0;
    gidx_c   = '0;
    accept_c = 1'b0;
    pos_c    = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos_c = {1'b0, rr_ptr_q} + (PTRW+1)'(k);
      if (pos_c >= (PTRW+1)'(NREQ)) begin
        pos_c = pos_c - (PTRW+1)'(NREQ);
      end
      for (int j = 0; j < NREQ; j++) begin
        if (!accept_c && req_valid[j] && (pos_c == (PTRW+1)'(j))) begin
          accept_c   = 1'b1;
          grant_c[j] = 1'b1;
          gidx_c     = PTRW'(j);
        end
      end
    end
    if (rst || hold) begin
      grant_c  = '0;
      accept_c = 1'b0;
    end
  end

  always_comb begin
    sel_addr_c = '0;
    sel_data_c = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_c[j]) begin
        sel_addr_c = req_addr[5*j +: 5];
        sel_data_c = req_data[32*j +: 32];
      end
    end
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    grant_id_d = grant_id_q;
    drop_cnt_d = drop_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    if (accept_c) begin
      rf_waddr_d = sel_addr_c;
      rf_wdata_d = sel_data_c;
      grant_id_d = gidx_c;
      rr_ptr_d   = (gidx_c == PTRW'(NREQ-1)) ? '0 : gidx_c + PTRW'(1);
      if (sel_addr_c != 5'd0) begin
        rf_we_d = 1'b1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      grant_id_q <= '0;
      drop_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      grant_id_q <= grant_id_d;
      drop_cnt_q <= drop_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign req_ready = grant_c;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign grant_id  = grant_id_q;
  assign drop_cnt  = drop_cnt_q;

`ifdef WB_BYPASS_EN
  // $0 is never forwarded; it must always read as whatever the file returns.
  assign byp_rdata1 = (rf_we_q && (rf_waddr_q == byp_raddr1) && (byp_raddr1 != 5'd0))
                      ? rf_wdata_q : byp_rdata1_in;
  assign byp_rdata2 = (rf_we_q && (rf_waddr_q == byp_raddr2) && (byp_raddr2 != 5'd0))
                      ? rf_wdata_q : byp_rdata2_in;
`else
  logic unused_byp;
  assign unused_byp = ^{byp_raddr1, byp_raddr2};
  assign byp_rdata1 = byp_rdata1_in;
  assign byp_rdata2 = byp_rdata2_in;
`endif

endmodule
